// File: rtl/tomasulo_run_pkg.sv
// tomasulo_run_pkg
//   Shared definitions for the run controller and its done tracker:
//   the controller FSM state encoding and default parameter values.
package tomasulo_run_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RESET   = 3'd1,
      ST_RUN     = 3'd2,
      ST_PASS    = 3'd3,
      ST_TIMEOUT = 3'd4
   } run_state_e;

   localparam int DEF_NUM_CORES      = 1;
   localparam int DEF_RST_CYCLES     = 2;
   localparam int DEF_TIMEOUT_CYCLES = 1000;
   localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/tomasulo_done_tracker.sv
// tomasulo_done_tracker
//   Per-core sticky completion mask, all-done detection and (optionally)
//   the run cycle at which each core first reported done.
//   Optional feature macro: TOMASULO_RUN_CTRL_CORE_CYCLES_EN
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   i_clr          clear mask (and captured cycles) on run-reset entry
//   i_en           tracking enabled (controller in RUN)
//   i_done         per-core done flags
//   i_cycle_cnt    current run cycle (macro only)
//   o_core_cycles  captured first-done cycle per core (macro only)
//   o_done_mask    sticky mask of cores that reported done
//   o_all_done     combinational: (mask | done) is all ones
module tomasulo_done_tracker
   import tomasulo_run_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_clr,
   input  logic                       i_en,
   input  logic [NUM_CORES-1:0]       i_done,
`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
   input  logic [CNT_W-1:0]           i_cycle_cnt,
   output logic [NUM_CORES*CNT_W-1:0] o_core_cycles,
`endif
   output logic [NUM_CORES-1:0]       o_done_mask,
   output logic                       o_all_done
);

   logic [NUM_CORES-1:0] r_mask;

   // Includes this cycle's done so a pulse arriving on the last pending
   // core completes the run in the same cycle it is seen.
   assign o_all_done  = &(r_mask | i_done);
   assign o_done_mask = r_mask;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_mask <= '0;
      end else if (i_en) begin
         r_mask <= r_mask | i_done;
      end
   end

`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
   logic [NUM_CORES-1:0]       w_first;
   logic [NUM_CORES*CNT_W-1:0] r_core_cycles;

   // Only the first done of each core is recorded; later pulses are ignored.
   assign w_first       = i_done & ~r_mask;
   assign o_core_cycles = r_core_cycles;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_core_cycles <= '0;
      end else if (i_en) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (w_first[i]) begin
               r_core_cycles[i*CNT_W +: CNT_W] <= i_cycle_cnt;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/tomasulo_run_ctrl.sv
// tomasulo_run_ctrl
//   Sequences a run of NUM_CORES processor instances: holds them in reset
//   for RST_CYCLES after start, counts run cycles, and ends in PASS once
//   every core has reported done or in TIMEOUT after TIMEOUT_CYCLES.
//   Optional feature macro: TOMASULO_RUN_CTRL_CORE_CYCLES_EN (adds
//   core_cycles, the run cycle at which each core first reported done).
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle run request (honoured in IDLE/PASS/TIMEOUT)
//   done         per-core completion flag, level or pulse
//   core_rst     per-core reset, high in IDLE and RESET
//   busy         high in RESET and RUN
//   finished     high in PASS and TIMEOUT
//   pass         high in PASS
//   cycle_cnt    run cycles elapsed, saturating
//   done_mask    sticky per-core done record
//   core_cycles  per-core first-done cycle, core i at [i*CNT_W +: CNT_W]
module tomasulo_run_ctrl
   import tomasulo_run_pkg::*;
#(
   parameter int NUM_CORES      = DEF_NUM_CORES,
   parameter int RST_CYCLES     = DEF_RST_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [NUM_CORES-1:0]       done,
   output logic [NUM_CORES-1:0]       core_rst,
   output logic                       busy,
   output logic                       finished,
   output logic                       pass,
   output logic [CNT_W-1:0]           cycle_cnt,
   output logic [NUM_CORES-1:0]       done_mask
`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
   ,
   output logic [NUM_CORES*CNT_W-1:0] core_cycles
`endif
);

   localparam int               RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   run_state_e           r_state;
   run_state_e           w_state_nxt;
   logic [RC_W-1:0]      r_rst_cnt;
   logic [CNT_W-1:0]     r_cycle_cnt;
   logic [NUM_CORES-1:0] r_core_rst;
   logic                 r_busy;
   logic                 r_finished;
   logic                 r_pass;
   logic                 w_all_done;
   logic                 w_clr;
   logic                 w_run;

   // Next-state logic. PASS is tested before the timeout so a completion
   // on the final allowed cycle still counts as a pass.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_RESET;
         end
         ST_RESET: begin
            if (r_rst_cnt == '0) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_all_done)                  w_state_nxt = ST_PASS;
            else if (r_cycle_cnt == TO_LAST) w_state_nxt = ST_TIMEOUT;
         end
         ST_PASS, ST_TIMEOUT: begin
            if (start) w_state_nxt = ST_RESET;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_clr = (w_state_nxt == ST_RESET) && (r_state != ST_RESET);
   assign w_run = (r_state == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rst_cnt <= '0;
      end else if (w_clr) begin
         r_rst_cnt <= RC_LOAD;
      end else if ((r_state == ST_RESET) && (r_rst_cnt != '0)) begin
         r_rst_cnt <= r_rst_cnt - RC_W'(1);
      end
   end

   // The counter stops on the cycle the run ends, so the final value is
   // the run cycle on which PASS/TIMEOUT was decided.
   always_ff @(posedge clk) begin
      if (rst || w_clr) begin
         r_cycle_cnt <= '0;
      end else if (w_run && (w_state_nxt == ST_RUN) && (r_cycle_cnt != CNT_MAX)) begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state and registered, so they line
   // up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_core_rst <= '1;
         r_busy     <= 1'b0;
         r_finished <= 1'b0;
         r_pass     <= 1'b0;
      end else begin
         r_core_rst <= {NUM_CORES{(w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RESET)}};
         r_busy     <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_RUN);
         r_finished <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_TIMEOUT);
         r_pass     <= (w_state_nxt == ST_PASS);
      end
   end

   tomasulo_done_tracker #(
      .NUM_CORES (NUM_CORES),
      .CNT_W     (CNT_W)
   ) u_tracker (
      .clk           (clk),
      .rst           (rst),
      .i_clr         (w_clr),
      .i_en          (w_run),
      .i_done        (done),
`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
      .i_cycle_cnt   (r_cycle_cnt),
      .o_core_cycles (core_cycles),
`endif
      .o_done_mask   (done_mask),
      .o_all_done    (w_all_done)
   );

   assign core_rst  = r_core_rst;
   assign busy      = r_busy;
   assign finished  = r_finished;
   assign pass      = r_pass;
   assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_tomasulo_run_ctrl.sv
// tb_tomasulo_run_ctrl
//   Self-checking bench for tomasulo_run_ctrl with four cores, a two-cycle
//   reset window and a 100-cycle timeout. A table of done-pulse schedules
//   is run back to back (each run restarts from PASS/TIMEOUT); expected
//   final results go through a scoreboard queue. Hand-written sequences
//   cover reset values and a mid-run abort.
//   Optional feature macro: TOMASULO_RUN_CTRL_CORE_CYCLES_EN
module tb_tomasulo_run_ctrl;

   localparam int NC = 4;
   localparam int RC = 2;
   localparam int TO = 100;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NC-1:0] done;
   logic [NC-1:0] core_rst;
   logic          busy;
   logic          finished;
   logic          pass;
   logic [CW-1:0] cycle_cnt;
   logic [NC-1:0] done_mask;
`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
   logic [NC*CW-1:0] core_cycles;
`endif

   tomasulo_run_ctrl #(
      .NUM_CORES      (NC),
      .RST_CYCLES     (RC),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .done        (done),
      .core_rst    (core_rst),
      .busy        (busy),
      .finished    (finished),
      .pass        (pass),
      .cycle_cnt   (cycle_cnt),
      .done_mask   (done_mask)
`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
      ,
      .core_cycles (core_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Done schedule: tN = run cycle on which core N pulses done, -1 = never.
   typedef struct {
      int            t0, t1, t2, t3;
      bit            hold;
      bit            exp_pass;
      int            exp_cnt;
      logic [NC-1:0] exp_mask;
   } vec_t;

   typedef struct {
      bit               pass;
      int               cnt;
      logic [NC-1:0]    mask;
      logic [NC*CW-1:0] cyc;
   } exp_t;

   vec_t vecs[7];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int tget(input vec_t v, input int i);
      case (i)
         0:       return v.t0;
         1:       return v.t1;
         2:       return v.t2;
         default: return v.t3;
      endcase
   endfunction

   function automatic logic [NC-1:0] mask_before(input vec_t v, input int k);
      logic [NC-1:0] m;
      m = '0;
      for (int i = 0; i < NC; i++) begin
         if (tget(v, i) >= 0 && tget(v, i) < k) m[i] = 1'b1;
      end
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_core_rst"}, core_rst, {NC{1'b1}});
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_finished"}, finished, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
      chk({tag, "_done_mask"}, done_mask, 0);
`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
      chk({tag, "_core_cycles"}, core_cycles[63:0], 0);
`endif
   endtask

   task automatic run_vector(input int idx, input vec_t v);
      exp_t e;
      int   k;
      bit   fin;
      e.pass = v.exp_pass;
      e.cnt  = v.exp_cnt;
      e.mask = v.exp_mask;
      e.cyc  = '0;
      for (int i = 0; i < NC; i++) begin
         if (tget(v, i) >= 0 && tget(v, i) <= v.exp_cnt) e.cyc[i*CW +: CW] = CW'(tget(v, i));
      end
      sb.push_back(e);

      // cycle 0: start request
      start = 1'b1;
      tick();
      if (!v.hold) start = 1'b0;
      // reset window: cycles 1..RC
      for (int c = 1; c <= RC; c++) begin
         chk($sformatf("v%0d_win%0d_core_rst", idx, c), core_rst, {NC{1'b1}});
         chk($sformatf("v%0d_win%0d_busy", idx, c), busy, 1);
         chk($sformatf("v%0d_win%0d_finished", idx, c), finished, 0);
         if (c == 1) begin
            chk($sformatf("v%0d_entry_cnt", idx), cycle_cnt, 0);
            chk($sformatf("v%0d_entry_mask", idx), done_mask, 0);
         end
         tick();
      end
      chk($sformatf("v%0d_run_core_rst", idx), core_rst, 0);

      k   = 0;
      fin = 1'b0;
      while (!fin && k <= TO + 5) begin
         chk($sformatf("v%0d_k%0d_cnt", idx, k), cycle_cnt, k);
         chk($sformatf("v%0d_k%0d_mask", idx, k), done_mask, mask_before(v, k));
         chk($sformatf("v%0d_k%0d_busy", idx, k), busy, 1);
         for (int i = 0; i < NC; i++) done[i] = (tget(v, i) == k);
         tick();
         done = '0;
         if (finished) begin
            start = 1'b0;
            fin   = 1'b1;
         end else begin
            k++;
         end
      end

      if (!fin) begin
         n_tests++;
         n_fail++;
         $display("FAIL v%0d_finish: no finished after %0d run cycles, expected at %0d", idx, k, e.cnt);
         void'(sb.pop_front());
         start = 1'b0;
         rst   = 1'b1;
         tick();
         rst   = 1'b0;
         return;
      end

      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL v%0d_scoreboard: queue empty, got 0 entries, expected 1", idx);
         return;
      end
      e = sb.pop_front();
      chk($sformatf("v%0d_end_cycle", idx), k, e.cnt);
      chk($sformatf("v%0d_pass", idx), pass, e.pass);
      chk($sformatf("v%0d_busy_end", idx), busy, 0);
      chk($sformatf("v%0d_core_rst_end", idx), core_rst, 0);
      chk($sformatf("v%0d_cnt_end", idx), cycle_cnt, e.cnt);
      chk($sformatf("v%0d_mask_end", idx), done_mask, e.mask);
`ifdef TOMASULO_RUN_CTRL_CORE_CYCLES_EN
      for (int i = 0; i < NC; i++) begin
         chk($sformatf("v%0d_core_cycles%0d", idx, i), core_cycles[i*CW +: CW], e.cyc[i*CW +: CW]);
      end
`endif
      // done is ignored once the run has ended
      done = '1;
      tick();
      done = '0;
      chk($sformatf("v%0d_frozen_cnt", idx), cycle_cnt, e.cnt);
      chk($sformatf("v%0d_frozen_mask", idx), done_mask, e.mask);
      chk($sformatf("v%0d_frozen_finished", idx), finished, 1);
      chk($sformatf("v%0d_frozen_pass", idx), pass, e.pass);
   endtask

   task automatic abort_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (RC) tick();
      repeat (15) tick();
      chk("abort_pre_cnt", cycle_cnt, 15);
      chk("abort_pre_busy", busy, 1);
      rst   = 1'b1;
      start = 1'b1;
      tick();
      chk_reset_vals("abort");
      tick();
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk_reset_vals("abort_idle");
   endtask

   initial begin
      vecs[0] = '{57, 57, 57, 57, 1'b0, 1'b1, 57, 4'b1111};
      vecs[1] = '{10, 20, 30, 40, 1'b0, 1'b1, 40, 4'b1111};
      vecs[2] = '{10, 20, -1, 40, 1'b0, 1'b0, 99, 4'b1011};
      vecs[3] = '{10, 20, 99, 40, 1'b0, 1'b1, 99, 4'b1111};
      vecs[4] = '{ 0,  0,  0,  0, 1'b0, 1'b1,  0, 4'b1111};
      vecs[5] = '{-1, -1, -1, -1, 1'b0, 1'b0, 99, 4'b0000};
      vecs[6] = '{98, 30, 98,  5, 1'b1, 1'b1, 98, 4'b1111};

      rst   = 1'b1;
      start = 1'b0;
      done  = '0;
      repeat (3) tick();
      chk_reset_vals("por");
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk_reset_vals("por_start_ignored");
      tick();
      chk_reset_vals("idle");

      for (int i = 0; i < 4; i++) run_vector(i, vecs[i]);
      abort_run();
      for (int i = 4; i < 7; i++) run_vector(i, vecs[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
